// File: rtl/bus_arbiter.sv
// Arbitrates the shared memory bus between a 68000 CPU (BR/BG/BGACK handshake) and an FPGA master.
// Define BUS_ARB_TIMEOUT_EN to bound FPGA tenure to TIMEOUT_CYCLES and enable the sticky timeout_err flag.
module bus_arbiter #(
  parameter int CPU_MIN_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic sysclk,
  input  logic mrst,
  input  logic fpga_req,
  output logic fpga_gnt,
  output logic br_n,
  input  logic bg_n,
  input  logic as_n,
  output logic bgack_n,
  output logic cpu_inctrl,
  output logic fpga_inctrl,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    CPU_OWN   = 3'd0,
    REQ       = 3'd1,
    WAIT_IDLE = 3'd2,
    GRANT     = 3'd3,
    FPGA_OWN  = 3'd4,
    RELEASE   = 3'd5
  } state_t;

  if (CPU_MIN_CYCLES < 1 || CPU_MIN_CYCLES > 255 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("bus_arbiter: parameter out of range");
  end

  state_t     state_r, state_s;
  logic       bg_meta_r, bg_s, as_meta_r, as_s;
  logic [7:0] holdoff_r;
  logic       idle_r;
  logic       forced_s, need_low_s;
  logic       fpga_gnt_r, br_n_r, bgack_n_r, cpu_inctrl_r, fpga_inctrl_r;
  logic       fpga_gnt_s, br_n_s, bgack_n_s, cpu_inctrl_s, fpga_inctrl_s;

  // Two-flop synchronizers for the asynchronous 68000 handshake inputs
  always_ff @(posedge sysclk or negedge mrst) begin
    if (!mrst) begin
      bg_meta_r <= 1'b1;
      bg_s      <= 1'b1;
      as_meta_r <= 1'b1;
      as_s      <= 1'b1;
    end else begin
      bg_meta_r <= bg_n;
      bg_s      <= bg_meta_r;
      as_meta_r <= as_n;
      as_s      <= as_meta_r;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] tenure_r;
  logic        need_low_r;
  logic        timeout_err_r;

  always_comb begin
    forced_s   = (state_r == FPGA_OWN) && ((tenure_r + 16'd1) == 16'(TIMEOUT_CYCLES));
    need_low_s = need_low_r;
  end

  // Tenure counter; a forced release also blocks regrant until fpga_req is seen low
  always_ff @(posedge sysclk or negedge mrst) begin
    if (!mrst) begin
      tenure_r      <= 16'd0;
      need_low_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      if (state_r == GRANT) begin
        tenure_r <= 16'd0;
      end else if (state_r == FPGA_OWN) begin
        tenure_r <= tenure_r + 16'd1;
      end else begin
        tenure_r <= tenure_r;
      end
      if (forced_s) begin
        need_low_r    <= 1'b1;
        timeout_err_r <= 1'b1;
      end else begin
        need_low_r    <= need_low_r & fpga_req;
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign forced_s    = 1'b0;
  assign need_low_s  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      CPU_OWN: begin
        if (fpga_req && (holdoff_r == 8'd0) && !need_low_s) state_s = REQ;
        else                                                 state_s = CPU_OWN;
      end
      REQ: begin
        if (!fpga_req)  state_s = CPU_OWN;
        else if (!bg_s) state_s = WAIT_IDLE;
        else            state_s = REQ;
      end
      WAIT_IDLE: begin
        if (as_s && idle_r) state_s = GRANT;
        else                state_s = WAIT_IDLE;
      end
      GRANT:    state_s = FPGA_OWN;
      FPGA_OWN: begin
        if (forced_s || !fpga_req) state_s = RELEASE;
        else                       state_s = FPGA_OWN;
      end
      RELEASE:  state_s = CPU_OWN;
      default:  state_s = CPU_OWN;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with state_r
  always_comb begin
    fpga_gnt_s    = 1'b0;
    br_n_s        = 1'b1;
    bgack_n_s     = 1'b1;
    cpu_inctrl_s  = 1'b0;
    fpga_inctrl_s = 1'b1;
    case (state_s)
      CPU_OWN:        cpu_inctrl_s = 1'b0;
      REQ, WAIT_IDLE: br_n_s = 1'b0;
      GRANT: begin
        bgack_n_s    = 1'b0;
        cpu_inctrl_s = 1'b1;
      end
      FPGA_OWN: begin
        bgack_n_s     = 1'b0;
        cpu_inctrl_s  = 1'b1;
        fpga_inctrl_s = 1'b0;
        fpga_gnt_s    = 1'b1;
      end
      RELEASE:        cpu_inctrl_s = 1'b1;
      default:        cpu_inctrl_s = 1'b0;
    endcase
  end

  // State, holdoff, idle tracking and output registers
  always_ff @(posedge sysclk or negedge mrst) begin
    if (!mrst) begin
      state_r       <= CPU_OWN;
      holdoff_r     <= 8'd0;
      idle_r        <= 1'b0;
      fpga_gnt_r    <= 1'b0;
      br_n_r        <= 1'b1;
      bgack_n_r     <= 1'b1;
      cpu_inctrl_r  <= 1'b0;
      fpga_inctrl_r <= 1'b1;
    end else begin
      state_r <= state_s;
      if (state_r == RELEASE) begin
        holdoff_r <= 8'(CPU_MIN_CYCLES);
      end else if ((state_r == CPU_OWN) && (holdoff_r != 8'd0)) begin
        holdoff_r <= holdoff_r - 8'd1;
      end else begin
        holdoff_r <= holdoff_r;
      end
      idle_r        <= (state_r == WAIT_IDLE) && as_s;
      fpga_gnt_r    <= fpga_gnt_s;
      br_n_r        <= br_n_s;
      bgack_n_r     <= bgack_n_s;
      cpu_inctrl_r  <= cpu_inctrl_s;
      fpga_inctrl_r <= fpga_inctrl_s;
    end
  end

  assign fpga_gnt    = fpga_gnt_r;
  assign br_n        = br_n_r;
  assign bgack_n     = bgack_n_r;
  assign cpu_inctrl  = cpu_inctrl_r;
  assign fpga_inctrl = fpga_inctrl_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, hand-written corner sequences, and random
// traffic compared against a timestamp-based reference model.
module tb_bus_arbiter;

  localparam int CPU_MIN = 16;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 4096;
  localparam bit TMO_EN = 1'b0;
`endif

  // {br_n, bgack_n, cpu_inctrl, fpga_inctrl, fpga_gnt, timeout_err}
  localparam logic [5:0] O_CPU   = 6'b110100;
  localparam logic [5:0] O_REQ   = 6'b010100;
  localparam logic [5:0] O_GRANT = 6'b101100;
  localparam logic [5:0] O_FPGA  = 6'b101010;
  localparam logic [5:0] O_REL   = 6'b111100;

  localparam int PH_CPU = 0, PH_REQ = 1, PH_WAIT = 2, PH_GRANT = 3, PH_FPGA = 4, PH_REL = 5;

  logic sysclk = 1'b0;
  logic mrst = 1'b0;
  logic fpga_req = 1'b0;
  logic bg_n = 1'b1;
  logic as_n = 1'b1;
  logic fpga_gnt, br_n, bgack_n, cpu_inctrl, fpga_inctrl, timeout_err;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.CPU_MIN_CYCLES(CPU_MIN), .TIMEOUT_CYCLES(TMO)) dut (
    .sysclk(sysclk), .mrst(mrst), .fpga_req(fpga_req), .fpga_gnt(fpga_gnt),
    .br_n(br_n), .bg_n(bg_n), .as_n(as_n), .bgack_n(bgack_n),
    .cpu_inctrl(cpu_inctrl), .fpga_inctrl(fpga_inctrl), .timeout_err(timeout_err)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Both strobe drivers may never be enabled together
  always @(negedge sysclk) begin
    checks++;
    if (!cpu_inctrl && !fpga_inctrl) begin
      errors++;
      $display("FAIL inctrl_overlap: cpu_inctrl=%b fpga_inctrl=%b both low at %0t", cpu_inctrl, fpga_inctrl, $time);
    end
  end

  function automatic logic [5:0] outs();
    return {br_n, bgack_n, cpu_inctrl, fpga_inctrl, fpga_gnt, timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: ownership phase plus timestamps of phase entry and last release
  int m_ph, m_edge, m_entry, m_last_rel;
  bit m_as_prev, m_err, m_need_low;
  bit m_bgq[$];
  bit m_asq[$];

  function automatic void m_reset();
    m_ph = PH_CPU; m_edge = 0; m_entry = 0; m_last_rel = -1000;
    m_as_prev = 1'b1; m_err = 1'b0; m_need_low = 1'b0;
    m_bgq = '{1'b1, 1'b1};
    m_asq = '{1'b1, 1'b1};
  endfunction

  function automatic void m_step(input bit req, input bit bg, input bit as_in);
    bit bgs, ass, forced;
    int nph;
    bgs = m_bgq.pop_front(); m_bgq.push_back(bg);
    ass = m_asq.pop_front(); m_asq.push_back(as_in);
    nph = m_ph;
    forced = 1'b0;
    case (m_ph)
      PH_CPU:   if (req && (m_edge - m_last_rel > CPU_MIN) && !m_need_low) nph = PH_REQ;
      PH_REQ:   if (!req) nph = PH_CPU; else if (!bgs) nph = PH_WAIT;
      PH_WAIT:  if (ass && m_as_prev && (m_edge - m_entry >= 2)) nph = PH_GRANT;
      PH_GRANT: nph = PH_FPGA;
      PH_FPGA: begin
        forced = TMO_EN && (m_edge - m_entry == TMO);
        if (forced || !req) nph = PH_REL;
      end
      PH_REL: begin
        nph = PH_CPU;
        m_last_rel = m_edge;
      end
      default: nph = PH_CPU;
    endcase
    if (forced) begin
      m_err = 1'b1;
      m_need_low = 1'b1;
    end else if (!req) begin
      m_need_low = 1'b0;
    end
    if (nph != m_ph) m_entry = m_edge;
    m_ph = nph;
    m_as_prev = ass;
    m_edge++;
  endfunction

  function automatic logic [5:0] m_exp();
    logic [5:0] o;
    case (m_ph)
      PH_CPU:          o = O_CPU;
      PH_REQ, PH_WAIT: o = O_REQ;
      PH_GRANT:        o = O_GRANT;
      PH_FPGA:         o = O_FPGA;
      PH_REL:          o = O_REL;
      default:         o = 6'b000000;
    endcase
    o[0] = m_err;
    return o;
  endfunction

  typedef struct {
    logic       req;
    logic       bg;
    logic       as_v;
    logic [5:0] exp;
  } vec_t;
  vec_t tab[$];

  function automatic void add(input logic r, input logic b, input logic a, input logic [5:0] e);
    vec_t v;
    v.req = r; v.bg = b; v.as_v = a; v.exp = e;
    tab.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge sysclk);
    mrst = 1'b0; fpga_req = 1'b0; bg_n = 1'b1; as_n = 1'b1;
    repeat (2) @(negedge sysclk);
    chk("reset_outputs", {26'd0, outs()}, {26'd0, O_CPU});
    mrst = 1'b1;
    m_reset();
  endtask

  initial begin
    int n;
    bit seen;

    // Basic grant, release, holdoff and abort in REQ
    add(1'b1, 1'b1, 1'b1, O_REQ);
    add(1'b1, 1'b1, 1'b1, O_REQ);
    add(1'b1, 1'b1, 1'b1, O_REQ);
    add(1'b1, 1'b0, 1'b1, O_REQ);
    add(1'b1, 1'b0, 1'b1, O_REQ);
    add(1'b1, 1'b0, 1'b1, O_REQ);
    add(1'b1, 1'b0, 1'b1, O_REQ);
    add(1'b1, 1'b0, 1'b1, O_GRANT);
    add(1'b1, 1'b0, 1'b1, O_FPGA);
    add(1'b1, 1'b1, 1'b1, O_FPGA);
    add(1'b0, 1'b1, 1'b1, O_REL);
    add(1'b1, 1'b1, 1'b1, O_CPU);
    for (int i = 0; i < CPU_MIN; i++) add(1'b1, 1'b1, 1'b1, O_CPU);
    add(1'b1, 1'b1, 1'b1, O_REQ);
    add(1'b0, 1'b1, 1'b1, O_CPU);
    add(1'b0, 1'b1, 1'b1, O_CPU);

    do_reset();
    for (int i = 0; i < tab.size(); i++) begin
      fpga_req = tab[i].req; bg_n = tab[i].bg; as_n = tab[i].as_v;
      @(negedge sysclk);
      chk($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, tab[i].exp});
    end

    // Bus busy: as_n held low after bg_n falls keeps the CPU on the bus
    fpga_req = 1'b1; bg_n = 1'b0; as_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sysclk);
      chk("busy_hold", {30'd0, bgack_n, cpu_inctrl}, 32'd2);
    end
    chk("busy_br_low", {31'd0, br_n}, 32'd0);
    as_n = 1'b1;
    n = 0;
    while (bgack_n && n < 10) begin
      @(negedge sysclk);
      n++;
    end
    chk("busy_grant_latency", n, 32'd4);
    chk("busy_grant_outs", {26'd0, outs()}, {26'd0, O_GRANT});
    @(negedge sysclk);
    chk("busy_fpga_outs", {26'd0, outs()}, {26'd0, O_FPGA});
    fpga_req = 1'b0;
    @(negedge sysclk);
    chk("busy_release", {26'd0, outs()}, {26'd0, O_REL});
    @(negedge sysclk);
    chk("busy_cpu_back", {26'd0, outs()}, {26'd0, O_CPU});

    // Reset asserted mid-tenure forces CPU ownership at once
    fpga_req = 1'b1; bg_n = 1'b0; as_n = 1'b1;
    n = 0;
    while (!fpga_gnt && n < 60) begin
      @(negedge sysclk);
      n++;
    end
    chk("midrst_gnt_reached", {31'd0, fpga_gnt}, 32'd1);
    mrst = 1'b0;
    #1;
    chk("midrst_immediate", {26'd0, outs()}, {26'd0, O_CPU});
    fpga_req = 1'b0; bg_n = 1'b1;
    @(negedge sysclk);
    chk("midrst_held", {26'd0, outs()}, {26'd0, O_CPU});
    mrst = 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
    // Forced release after TMO cycles, then no regrant until fpga_req toggles
    do_reset();
    fpga_req = 1'b1; bg_n = 1'b0; as_n = 1'b1;
    n = 0;
    while (!fpga_gnt && n < 60) begin
      @(negedge sysclk);
      n++;
    end
    chk("tmo_gnt_reached", {31'd0, fpga_gnt}, 32'd1);
    n = 0;
    while (fpga_gnt && n < 30) begin
      @(negedge sysclk);
      n++;
    end
    chk("tmo_tenure_len", n, TMO);
    chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sysclk);
      if (!br_n) seen = 1'b1;
    end
    chk("tmo_no_regrant", {31'd0, seen}, 32'd0);
    fpga_req = 1'b0;
    @(negedge sysclk);
    fpga_req = 1'b1;
    n = 0;
    while (br_n && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    chk("tmo_regrant_after_toggle", {31'd0, br_n}, 32'd0);
    chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
`endif

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      chk($sformatf("rand%0d", c), {26'd0, outs()}, {26'd0, m_exp()});
      if ($urandom_range(0, 11) == 0) fpga_req = ~fpga_req;
      if ($urandom_range(0, 3) == 0) bg_n = ~bg_n;
      if ($urandom_range(0, 2) == 0) as_n = ~as_n;
      m_step(fpga_req, bg_n, as_n);
      @(negedge sysclk);
    end
    chk("rand_final", {26'd0, outs()}, {26'd0, m_exp()});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter CPU_MIN_CYCLES, default 16: minimum sysclk cycles the CPU keeps the bus after each FPGA tenure, range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum FPGA tenure in sysclk cycles, range 2..65535; used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-003 sysclk  in  1  single clock; every flop is rising-edge on sysclk.
REQ-004 mrst  in  1  asynchronous active-low reset.
REQ-005 fpga_req  in  1  FPGA bus request, active-high, synchronous to sysclk.
REQ-006 fpga_gnt  out  1  FPGA owns the bus, active-high.
REQ-007 br_n  out  1  68000 bus request, active-low.
REQ-008 bg_n  in  1  68000 bus grant, active-low, asynchronous.
REQ-009 as_n  in  1  68000 address strobe, active-low, asynchronous.
REQ-010 bgack_n  out  1  68000 bus-grant acknowledge, active-low.
REQ-011 cpu_inctrl  out  1  low means CPU strobes drive the memory bus.
REQ-012 fpga_inctrl  out  1  low means FPGA strobes drive the memory bus.
REQ-013 timeout_err  out  1  sticky tenure-timeout flag; constant 0 without BUS_ARB_TIMEOUT_EN.

Function
REQ-014 bg_n and as_n shall each pass a 2-flop synchronizer; all decisions use the synchronized values (bg_s, as_s).
REQ-015 The FSM shall have exactly these states: CPU_OWN, REQ, WAIT_IDLE, GRANT, FPGA_OWN, RELEASE.
REQ-016 CPU_OWN: cpu_inctrl=0, fpga_inctrl=1, br_n=1, bgack_n=1, fpga_gnt=0.
REQ-017 CPU_OWN -> REQ when fpga_req=1 and the holdoff counter equals 0; REQ drives br_n=0.
REQ-018 REQ -> WAIT_IDLE when bg_s=0; if fpga_req drops while in REQ, the FSM shall return to CPU_OWN with br_n=1 on the next cycle.
REQ-019 WAIT_IDLE -> GRANT when as_s=1 for 2 consecutive cycles.
REQ-020 GRANT, one cycle: bgack_n=0, br_n=1, cpu_inctrl=1, fpga_inctrl=1 (dead cycle); then -> FPGA_OWN.
REQ-021 FPGA_OWN: bgack_n=0, fpga_inctrl=0, cpu_inctrl=1, fpga_gnt=1.
REQ-022 FPGA_OWN -> RELEASE when fpga_req=0 (sampled).
REQ-023 RELEASE, one cycle: fpga_gnt=0, both inctrl=1, bgack_n=1; then -> CPU_OWN, reloading the holdoff counter with CPU_MIN_CYCLES.
REQ-024 The holdoff counter shall decrement once per cycle in CPU_OWN, saturate at 0, and never wrap.
REQ-025 cpu_inctrl and fpga_inctrl shall never be 0 at the same time; every ownership change shall include at least one cycle with both at 1.
REQ-026 All outputs shall be registered; no output shall glitch combinationally.
REQ-027 fpga_gnt rises exactly 1 cycle after the FSM enters FPGA_OWN's predecessor GRANT completes, i.e. in the first FPGA_OWN cycle.
REQ-028 fpga_req asserted in the same cycle that RELEASE completes shall not be honored until the holdoff expires.

Reset
REQ-029 While mrst=0, the block shall be in CPU_OWN with holdoff=0 and outputs cpu_inctrl=0, fpga_inctrl=1, br_n=1, bgack_n=1, fpga_gnt=0, timeout_err=0; synchronizer flops shall be 1.
REQ-030 mrst asserted in any state, including mid-tenure, shall immediately force the reset outputs without passing through RELEASE.

Configuration
REQ-031 Macro BUS_ARB_TIMEOUT_EN: when defined, a 16-bit tenure counter shall clear on GRANT and increment in FPGA_OWN.
REQ-032 With BUS_ARB_TIMEOUT_EN defined: when the tenure counter reaches TIMEOUT_CYCLES, the FSM shall go to RELEASE regardless of fpga_req and set timeout_err=1 until mrst.
REQ-033 With BUS_ARB_TIMEOUT_EN defined: after a forced release, a new grant shall require fpga_req to be seen low for at least 1 cycle.
REQ-034 Without BUS_ARB_TIMEOUT_EN: the tenure counter shall be absent, FPGA tenure shall be unbounded, and timeout_err shall be tied to 0.

Verification
REQ-035 Basic grant: reset, fpga_req=1, bg_n=0 after 3 cycles, as_n=1 -> br_n low, then bgack_n low; fpga_gnt=1 exactly 1 dead cycle after GRANT; fpga_inctrl=0.
REQ-036 Bus busy: hold as_n=0 for 10 cycles after bg_n=0 -> no GRANT until 2 synchronized idle cycles; cpu_inctrl stays 0 throughout.
REQ-037 Holdoff: drop fpga_req, then reassert it the next cycle -> br_n stays 1 for CPU_MIN_CYCLES=16 cycles in CPU_OWN.
REQ-038 Abort in REQ: fpga_req=1, then fpga_req=0 before bg_n falls -> br_n returns to 1 and bgack_n never asserts.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=8): hold fpga_req=1 -> forced release after 8 FPGA_OWN cycles; timeout_err=1; no regrant until fpga_req toggles.
REQ-040 Mid-tenure reset: mrst=0 during FPGA_OWN -> same cycle cpu_inctrl=0, fpga_inctrl=1, bgack_n=1; an assertion checks both inctrl are never 0 together over all tests.
